idma_channel_scheduler: RTL and testbench

// Shares one iDMA backend between NumChannels frontends (e.g. several reg64 frontends / cores).

---
 rtl/idma_channel_scheduler_pkg.sv | 21 ++
 rtl/idma_channel_scheduler_if.sv | 32 +++
 rtl/idma_rr_arbiter.sv | 33 +++
 rtl/idma_channel_scheduler.sv | 169 ++++++++++++++++
 tb/tb_idma_channel_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/idma_channel_scheduler_pkg.sv
// Shared types and helpers for the iDMA channel scheduler.
package idma_channel_scheduler_pkg;

   // Burst request forwarded unchanged from a frontend channel to the backend.
   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [15:0] length;
   } idma_req_t;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_ISSUE
   } sched_state_e;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int unsigned chan_id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/idma_channel_scheduler_if.sv
// Frontend-channel and backend handshake bundle of the iDMA channel scheduler.
interface idma_channel_scheduler_if #(
   parameter int unsigned NumChannels = 4
);
   import idma_channel_scheduler_pkg::*;

   idma_req_t [NumChannels-1:0] ch_req_i;
   logic      [NumChannels-1:0] ch_valid_i;
   logic      [NumChannels-1:0] ch_ready_o;
   logic      [NumChannels-1:0] ch_done_o;
   logic      [NumChannels-1:0] ch_busy_o;
   logic      [NumChannels-1:0] irq_o;
   logic      [NumChannels-1:0] irq_clr_i;
   idma_req_t                   be_req_o;
   logic                        be_valid_o;
   logic                        be_ready_i;
   logic                        be_rsp_valid_i;
   logic                        err_o;

   // Scheduler side.
   modport slave (
      input  ch_req_i, ch_valid_i, irq_clr_i, be_ready_i, be_rsp_valid_i,
      output ch_ready_o, ch_done_o, ch_busy_o, irq_o, be_req_o, be_valid_o, err_o
   );

   // Frontends/backend side.
   modport master (
      output ch_req_i, ch_valid_i, irq_clr_i, be_ready_i, be_rsp_valid_i,
      input  ch_ready_o, ch_done_o, ch_busy_o, irq_o, be_req_o, be_valid_o, err_o
   );

endinterface

// File: rtl/idma_rr_arbiter.sv
// Round-robin pick: first valid channel at or after the pointer, wrapping to 0.
module idma_rr_arbiter
   import idma_channel_scheduler_pkg::*;
#(
   parameter int unsigned NumChannels = 4,
   parameter int unsigned ChanIdWidth = chan_id_width(NumChannels)
) (
   input  logic [NumChannels-1:0] valid_i,
   input  logic [ChanIdWidth-1:0] ptr_i,
   output logic [NumChannels-1:0] gnt_o,
   output logic [ChanIdWidth-1:0] idx_o,
   output logic                   any_o
);

   logic [ChanIdWidth-1:0] cand;

   // Scan NumChannels candidates starting at the pointer; keep the first valid one.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NumChannels; k++) begin
         cand = ChanIdWidth'((32'(ptr_i) + k) % NumChannels);
         if (!any_o && valid_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/idma_channel_scheduler.sv
// Shares one iDMA backend between NumChannels frontends: round-robin grant,
// registered issue stage, in-order completion tracking, done pulses and sticky IRQs.
// MaxOutstanding must be a power of two (tracker pointers wrap naturally).
module idma_channel_scheduler
   import idma_channel_scheduler_pkg::*;
#(
   parameter int unsigned NumChannels    = 4,
   parameter int unsigned MaxOutstanding = 4
) (
   input logic                     clk_i,
   input logic                     rst_i,
   idma_channel_scheduler_if.slave bus
);

   localparam int unsigned ChanIdWidth = chan_id_width(NumChannels);
   localparam int unsigned PtrWidth    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntWidth    = $clog2(MaxOutstanding + 1);

   typedef logic [ChanIdWidth-1:0] chan_idx_t;
   typedef logic [CntWidth-1:0]    cnt_t;
   typedef logic [PtrWidth-1:0]    ptr_t;

   sched_state_e state_q, state_d;
   chan_idx_t    rr_ptr_q, rr_ptr_d;
   idma_req_t    be_req_q, be_req_d;

   chan_idx_t    trk_mem_q [MaxOutstanding];
   chan_idx_t    trk_mem_d [MaxOutstanding];
   ptr_t         trk_wr_q, trk_wr_d;
   ptr_t         trk_rd_q, trk_rd_d;
   cnt_t         trk_cnt_q, trk_cnt_d;

   cnt_t         outstanding_q [NumChannels];
   cnt_t         outstanding_d [NumChannels];
   logic [NumChannels-1:0] irq_q, irq_d;
   logic         err_q, err_d;

   logic [NumChannels-1:0] arb_gnt;
   chan_idx_t    arb_idx;
   logic         arb_any;

   logic         grant;
   logic         trk_full;
   logic         trk_empty;
   logic         trk_pop;
   chan_idx_t    trk_head;
   logic [NumChannels-1:0] done;
   logic [NumChannels-1:0] busy;

   idma_rr_arbiter #(
      .NumChannels (NumChannels),
      .ChanIdWidth (ChanIdWidth)
   ) i_rr_arbiter (
      .valid_i (bus.ch_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // Full is judged on the registered count, so a same-cycle pop does not free a slot early.
   assign trk_full  = (trk_cnt_q == cnt_t'(MaxOutstanding));
   assign trk_empty = (trk_cnt_q == '0);
   assign trk_pop   = bus.be_rsp_valid_i && !trk_empty;
   assign trk_head  = trk_mem_q[trk_rd_q];

   // Issue FSM: grant in IDLE (latching the winner's request), hold it valid in ISSUE.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      be_req_d = be_req_q;
      grant    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Reset gating keeps ch_ready_o low while reset is asserted.
            if (!rst_i && arb_any && !trk_full) begin
               grant    = 1'b1;
               be_req_d = bus.ch_req_i[arb_idx];
               rr_ptr_d = chan_idx_t'((32'(arb_idx) + 1) % NumChannels);
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.be_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Completion tracker: push granted channel id, pop the head on each backend completion.
   always_comb begin
      trk_mem_d = trk_mem_q;
      trk_wr_d  = trk_wr_q;
      trk_rd_d  = trk_rd_q;
      trk_cnt_d = trk_cnt_q;
      if (grant) begin
         trk_mem_d[trk_wr_q] = arb_idx;
         trk_wr_d            = trk_wr_q + ptr_t'(1);
      end
      if (trk_pop) begin
         trk_rd_d = trk_rd_q + ptr_t'(1);
      end
      if (grant && !trk_pop) begin
         trk_cnt_d = trk_cnt_q + cnt_t'(1);
      end else if (!grant && trk_pop) begin
         trk_cnt_d = trk_cnt_q - cnt_t'(1);
      end
   end

   // Per-channel done pulses, outstanding counters, sticky IRQs (set beats clear) and error flag.
   always_comb begin
      done          = '0;
      busy          = '0;
      outstanding_d = outstanding_q;
      irq_d         = irq_q;
      err_d         = err_q;
      for (int unsigned c = 0; c < NumChannels; c++) begin
         done[c] = trk_pop && (trk_head == chan_idx_t'(c));
         busy[c] = (outstanding_q[c] != '0);
         if (grant && arb_gnt[c] && !done[c]) begin
            outstanding_d[c] = outstanding_q[c] + cnt_t'(1);
         end else if (!(grant && arb_gnt[c]) && done[c]) begin
            outstanding_d[c] = outstanding_q[c] - cnt_t'(1);
         end
      end
      irq_d = done | (irq_q & ~bus.irq_clr_i);
      if (bus.be_rsp_valid_i && trk_empty) begin
         err_d = 1'b1;
      end
   end

   // State registers; reset discards all in-flight bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         be_req_q      <= '0;
         trk_mem_q     <= '{default: '0};
         trk_wr_q      <= '0;
         trk_rd_q      <= '0;
         trk_cnt_q     <= '0;
         outstanding_q <= '{default: '0};
         irq_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         be_req_q      <= be_req_d;
         trk_mem_q     <= trk_mem_d;
         trk_wr_q      <= trk_wr_d;
         trk_rd_q      <= trk_rd_d;
         trk_cnt_q     <= trk_cnt_d;
         outstanding_q <= outstanding_d;
         irq_q         <= irq_d;
         err_q         <= err_d;
      end
   end

   assign bus.ch_ready_o = grant ? arb_gnt : '0;
   assign bus.ch_done_o  = done;
   assign bus.ch_busy_o  = busy;
   assign bus.irq_o      = irq_q;
   assign bus.be_req_o   = be_req_q;
   assign bus.be_valid_o = (state_q == ST_ISSUE);
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_idma_channel_scheduler.sv
// Directed bench for idma_channel_scheduler with a queue-based reference model.
module tb_idma_channel_scheduler;
   import idma_channel_scheduler_pkg::*;

   localparam int NCH = 4;
   localparam int MO  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   idma_channel_scheduler_if #(.NumChannels(NCH)) bus();

   idma_channel_scheduler #(
      .NumChannels    (NCH),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic idma_req_t mk(input int c, input int n);
      idma_req_t r;
      r.src_addr = 32'h1000_0000 + 32'(c * 256 + n);
      r.dst_addr = 32'h2000_0000 + 32'(n * 256 + c);
      r.length   = 16'(64 + c * 8 + n);
      return r;
   endfunction

   function automatic logic [NCH-1:0] oh(input int c);
      logic [NCH-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NCH-1:0] v, input int p);
      for (int k = 0; k < NCH; k++) begin
         if (v[(p + k) % NCH]) return (p + k) % NCH;
      end
      return -1;
   endfunction

   // Reference model: queue of outstanding channel ids in completion order.
   int        m_q[$];
   int        m_out[NCH];
   int        m_ptr;
   bit        m_issuing;
   idma_req_t m_req;
   logic [NCH-1:0] m_irq;
   logic      m_err;

   // Cycle compare against the model on the falling edge, then advance the model.
   always @(negedge clk) begin
      logic [NCH-1:0] e_ready, e_done, e_busy;
      int w, h;
      if (rst) begin
         m_q.delete();
         for (int c = 0; c < NCH; c++) m_out[c] = 0;
         m_ptr = 0; m_issuing = 0; m_req = '0; m_irq = '0; m_err = 0;
         chk("rst_ready", bus.ch_ready_o, '0);
         chk("rst_done", bus.ch_done_o, '0);
         chk("rst_busy", bus.ch_busy_o, '0);
         chk("rst_irq", bus.irq_o, '0);
         chk("rst_be_valid", bus.be_valid_o, 1'b0);
         chk("rst_be_req", bus.be_req_o, '0);
         chk("rst_err", bus.err_o, 1'b0);
      end else begin
         w = -1;
         if (!m_issuing && m_q.size() < MO) w = rr_pick(bus.ch_valid_i, m_ptr);
         e_ready = (w >= 0) ? oh(w) : '0;
         e_done  = (bus.be_rsp_valid_i && m_q.size() > 0) ? oh(m_q[0]) : '0;
         for (int c = 0; c < NCH; c++) e_busy[c] = (m_out[c] != 0);
         chk("m_ready", bus.ch_ready_o, e_ready);
         chk("m_done", bus.ch_done_o, e_done);
         chk("m_busy", bus.ch_busy_o, e_busy);
         chk("m_irq", bus.irq_o, m_irq);
         chk("m_be_valid", bus.be_valid_o, m_issuing);
         chk("m_be_req", bus.be_req_o, m_req);
         chk("m_err", bus.err_o, m_err);
         if (bus.be_rsp_valid_i) begin
            if (m_q.size() > 0) begin
               h = m_q.pop_front();
               m_out[h]--;
            end else begin
               m_err = 1'b1;
            end
         end
         m_irq = (m_irq & ~bus.irq_clr_i) | e_done;
         if (w >= 0) begin
            m_q.push_back(w);
            m_out[w]++;
            m_req     = bus.ch_req_i[w];
            m_ptr     = (w + 1) % NCH;
            m_issuing = 1'b1;
         end else if (m_issuing && bus.be_ready_i) begin
            m_issuing = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ch_valid_i     = '0;
      bus.irq_clr_i      = '0;
      bus.be_ready_i     = 1'b0;
      bus.be_rsp_valid_i = 1'b0;
      for (int c = 0; c < NCH; c++) bus.ch_req_i[c] = mk(c, 0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int seq[5];
      int drn[4];
      seq = '{0, 1, 2, 3, 0};
      drn = '{2, 3, 0, 1};
      do_reset();

      // Single ch1 request, immediate backend ready, completion and IRQ clear.
      bus.ch_req_i[1] = mk(1, 1); bus.ch_valid_i = 4'b0010; bus.be_ready_i = 1'b1;
      #1 chk("t1_ready", bus.ch_ready_o, 4'b0010);
      tick(); bus.ch_valid_i = '0;
      #1 chk("t1_be_valid", bus.be_valid_o, 1'b1); chk("t1_be_req", bus.be_req_o, mk(1, 1));
      chk("t1_busy", bus.ch_busy_o, 4'b0010);
      tick(); bus.be_rsp_valid_i = 1'b1;
      #1 chk("t1_be_idle", bus.be_valid_o, 1'b0); chk("t1_done", bus.ch_done_o, 4'b0010);
      tick(); bus.be_rsp_valid_i = 1'b0;
      #1 chk("t1_irq_set", bus.irq_o, 4'b0010); chk("t1_busy_clr", bus.ch_busy_o, 4'b0000);
      bus.irq_clr_i = 4'b0010;
      tick(); bus.irq_clr_i = '0;
      #1 chk("t1_irq_clr", bus.irq_o, 4'b0000);

      // All channels continuously valid: grant order 0,1,2,3,0.
      do_reset();
      for (int c = 0; c < NCH; c++) bus.ch_req_i[c] = mk(c, 2);
      bus.ch_valid_i = 4'b1111; bus.be_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.be_rsp_valid_i = (i % 2 == 1);
         #1;
         if (i % 2 == 0) chk("t2_gnt", bus.ch_ready_o, oh(seq[i/2]));
         else begin
            chk("t2_be_req", bus.be_req_o, mk(seq[i/2], 2));
            chk("t2_done", bus.ch_done_o, oh(seq[i/2]));
         end
         tick();
      end

      // Backend stalls 5 cycles: request held stable, channel inputs ignored.
      bus.be_rsp_valid_i = 1'b0; bus.ch_valid_i = 4'b1000; bus.ch_req_i[3] = mk(3, 7);
      bus.be_ready_i = 1'b0;
      #1 chk("t3_gnt3", bus.ch_ready_o, 4'b1000);
      tick();
      bus.ch_valid_i = 4'b1111;
      for (int c = 0; c < NCH; c++) bus.ch_req_i[c] = mk(c, 9);
      for (int i = 0; i < 5; i++) begin
         #1 chk("t3_hold_valid", bus.be_valid_o, 1'b1); chk("t3_hold_req", bus.be_req_o, mk(3, 7));
         chk("t3_no_ready", bus.ch_ready_o, 4'b0000);
         tick();
      end
      bus.be_ready_i = 1'b1;
      tick();
      #1 chk("t3_gnt0", bus.ch_ready_o, 4'b0001);
      tick(); bus.ch_valid_i = '0; bus.be_rsp_valid_i = 1'b1;
      #1 chk("t3_be_req0", bus.be_req_o, mk(0, 9)); chk("t3_done3", bus.ch_done_o, 4'b1000);
      tick();
      #1 chk("t3_done0", bus.ch_done_o, 4'b0001);
      tick(); bus.be_rsp_valid_i = 1'b0; bus.irq_clr_i = 4'b1111;
      tick(); bus.irq_clr_i = '0;
      #1 chk("t3_irq_clr", bus.irq_o, 4'b0000);

      // Four issues without completions: fifth stalls until one completion frees a slot.
      for (int c = 0; c < NCH; c++) bus.ch_req_i[c] = mk(c, 4);
      bus.ch_valid_i = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         bus.be_rsp_valid_i = (i == 10);
         #1;
         if (i < 8 && i % 2 == 0) chk("t4_gnt", bus.ch_ready_o, oh((1 + i / 2) % NCH));
         if (i >= 8 && i <= 10) begin
            chk("t4_stall_ready", bus.ch_ready_o, 4'b0000);
            chk("t4_stall_valid", bus.be_valid_o, 1'b0);
         end
         if (i == 10) chk("t4_done1", bus.ch_done_o, 4'b0010);
         if (i == 11) chk("t4_resume", bus.ch_ready_o, 4'b0010);
         tick();
      end
      bus.ch_valid_i = '0; bus.be_rsp_valid_i = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1 chk("t4_drain", bus.ch_done_o, oh(drn[j]));
         tick();
      end
      bus.be_rsp_valid_i = 1'b0; bus.irq_clr_i = 4'b1111;
      tick(); bus.irq_clr_i = '0;

      // Interleaved ch2, ch0, ch2 issues then three completions.
      bus.ch_valid_i = 4'b0100; bus.ch_req_i[2] = mk(2, 5);
      #1 chk("t5_gnt2a", bus.ch_ready_o, 4'b0100);
      tick(); bus.ch_valid_i = '0;
      tick(); bus.ch_valid_i = 4'b0001; bus.ch_req_i[0] = mk(0, 5);
      #1 chk("t5_gnt0", bus.ch_ready_o, 4'b0001);
      tick(); bus.ch_valid_i = '0;
      tick(); bus.ch_valid_i = 4'b0100; bus.ch_req_i[2] = mk(2, 6);
      #1 chk("t5_gnt2b", bus.ch_ready_o, 4'b0100);
      tick(); bus.ch_valid_i = '0;
      #1 chk("t5_busy", bus.ch_busy_o, 4'b0101); chk("t5_be_req", bus.be_req_o, mk(2, 6));
      tick(); bus.be_rsp_valid_i = 1'b1;
      #1 chk("t5_done_a", bus.ch_done_o, 4'b0100);
      tick();
      #1 chk("t5_done_b", bus.ch_done_o, 4'b0001); chk("t5_busy_b", bus.ch_busy_o, 4'b0101);
      tick();
      #1 chk("t5_done_c", bus.ch_done_o, 4'b0100); chk("t5_busy_c", bus.ch_busy_o, 4'b0100);
      tick(); bus.be_rsp_valid_i = 1'b0;
      #1 chk("t5_busy_d", bus.ch_busy_o, 4'b0000); chk("t5_irq", bus.irq_o, 4'b0101);
      tick();

      // Completion with empty tracker; then IRQ set and clear in the same cycle.
      bus.be_rsp_valid_i = 1'b1;
      #1 chk("t6_no_done", bus.ch_done_o, 4'b0000); chk("t6_err_pre", bus.err_o, 1'b0);
      tick(); bus.be_rsp_valid_i = 1'b0;
      #1 chk("t6_err", bus.err_o, 1'b1);
      bus.ch_valid_i = 4'b0100; bus.ch_req_i[2] = mk(2, 7);
      #1 chk("t6_gnt2", bus.ch_ready_o, 4'b0100);
      tick(); bus.ch_valid_i = '0;
      tick(); bus.be_rsp_valid_i = 1'b1; bus.irq_clr_i = 4'b0100;
      #1 chk("t6_done2", bus.ch_done_o, 4'b0100);
      tick(); bus.be_rsp_valid_i = 1'b0; bus.irq_clr_i = 4'b0100;
      #1 chk("t6_irq_set_wins", bus.irq_o, 4'b0101); chk("t6_err_sticky", bus.err_o, 1'b1);
      tick(); bus.irq_clr_i = '0;
      #1 chk("t6_irq_clr", bus.irq_o, 4'b0001);

      // Reset while a request is being issued.
      bus.ch_valid_i = 4'b0010; bus.ch_req_i[1] = mk(1, 3); bus.be_ready_i = 1'b0;
      tick();
      #1 chk("t7_issuing", bus.be_valid_o, 1'b1);
      rst = 1'b1;
      #1 chk("t7_rst_valid", bus.be_valid_o, 1'b0); chk("t7_rst_req", bus.be_req_o, '0);
      chk("t7_rst_ready", bus.ch_ready_o, 4'b0000); chk("t7_rst_err", bus.err_o, 1'b0);
      tick(); tick(); rst = 1'b0;
      #1 chk("t7_post_gnt", bus.ch_ready_o, 4'b0010);
      tick(); bus.ch_valid_i = '0; bus.be_ready_i = 1'b1;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
